// File: rtl/axis_video_pkg.sv
// axis_video_pkg: shared pattern/state types and counter-width helpers for the AXI-Stream video blocks
package axis_video_pkg;
  typedef enum logic [1:0] {PAT_HRAMP, PAT_VRAMP, PAT_CHECK, PAT_CONST} pattern_t;
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;
  localparam int FRAME_CNT_W = 16;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int blank_w(input int hb, input int vb);
    return cnt_w((hb > vb ? hb : vb) + 1);
  endfunction
endpackage

// File: rtl/axis_stream_if.sv
// AxiStreamIf: AXI-Stream video bus carrying pixels with SOF on tuser and EOL on tlast
interface AxiStreamIf #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;
  modport Master(output tdata, tvalid, tlast, tuser, input tready);
  modport Slave(input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_pattern_pixel.sv
// axis_pattern_pixel: combinational test-pattern map (x, y, sel, fill) -> pixel
module axis_pattern_pixel
  import axis_video_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic [XW-1:0]         x,
  input  logic [YW-1:0]         y,
  input  pattern_t              sel,
  input  logic [DATA_WIDTH-1:0] fill,
  output logic [DATA_WIDTH-1:0] pixel
);
  logic check;
  always_comb begin
    check = ((32'(x) ^ 32'(y)) & 32'd8) != 32'd0;
    pixel = sel == PAT_HRAMP ? DATA_WIDTH'(x)
          : sel == PAT_VRAMP ? DATA_WIDTH'(y)
          : sel == PAT_CHECK ? {DATA_WIDTH{check}}
          : fill;
  end
endmodule

// File: rtl/axis_frame_source.sv
// axis_frame_source: AXI-Stream test-pattern frame transmitter with backpressure and H/V blanking
module axis_frame_source
  import axis_video_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 512,
  parameter int HBLANK       = 0,
  parameter int VBLANK       = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   continuous,
  input  logic [1:0]             pattern_sel,
  input  logic [DATA_WIDTH-1:0]  fill_value,
  AxiStreamIf.Master             m_axis,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);
  localparam int XW = cnt_w(FRAME_WIDTH);
  localparam int YW = cnt_w(FRAME_HEIGHT);
  localparam int BW = blank_w(HBLANK, VBLANK);
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);
  localparam logic [BW-1:0] H_LAST = BW'(HBLANK > 0 ? HBLANK - 1 : 0);
  localparam logic [BW-1:0] V_LAST = BW'(VBLANK > 0 ? VBLANK - 1 : 0);
  state_t                state, nstate;
  logic [XW-1:0]         x, nx;
  logic [YW-1:0]         y, ny;
  logic [BW-1:0]         bcnt, nbcnt;
  pattern_t              sel, nsel;
  logic [DATA_WIDTH-1:0] fill, nfill, pix, tdata_d;
  logic                  xfer, eol, eof, tvalid_d, tlast_d, tuser_d;
  axis_pattern_pixel #(.DATA_WIDTH(DATA_WIDTH), .XW(XW), .YW(YW)) u_pix (
    .x(nx), .y(ny), .sel(nsel), .fill(nfill), .pixel(pix)
  );
  // x/y hold the beat on the bus while ACTIVE and the next beat while blanking
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= S_IDLE;
      x             <= '0;
      y             <= '0;
      bcnt          <= '0;
      sel           <= PAT_HRAMP;
      fill          <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tlast  <= 1'b0;
      m_axis.tuser  <= 1'b0;
      frame_done    <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      state         <= nstate;
      x             <= nx;
      y             <= ny;
      bcnt          <= nbcnt;
      sel           <= nsel;
      fill          <= nfill;
      m_axis.tvalid <= tvalid_d;
      m_axis.tdata  <= tdata_d;
      m_axis.tlast  <= tlast_d;
      m_axis.tuser  <= tuser_d;
      frame_done    <= xfer && eof;
      frame_cnt     <= frame_cnt + FRAME_CNT_W'(xfer && eof);
    end
  always_comb begin
    xfer   = state == S_ACTIVE && m_axis.tready;
    eol    = x == X_LAST;
    eof    = eol && y == Y_LAST;
    nstate = state;
    nx     = x;
    ny     = y;
    nbcnt  = '0;
    nsel   = sel;
    nfill  = fill;
    case (state)
      S_IDLE: if (start) begin
        nstate = S_ACTIVE;
        nsel   = pattern_t'(pattern_sel);
        nfill  = fill_value;
      end
      S_ACTIVE: if (xfer) begin
        nx     = eol ? '0 : x + 1'b1;
        ny     = eof ? '0 : eol ? y + 1'b1 : y;
        nstate = !eol ? S_ACTIVE
               : !eof ? (HBLANK > 0 ? S_HBLANK : S_ACTIVE)
               : !continuous ? S_IDLE
               : VBLANK > 0 ? S_VBLANK : S_ACTIVE;
      end
      S_HBLANK: begin
        nbcnt  = bcnt + 1'b1;
        nstate = bcnt == H_LAST ? S_ACTIVE : S_HBLANK;
      end
      default: begin
        nbcnt  = bcnt + 1'b1;
        nstate = bcnt == V_LAST ? S_ACTIVE : S_VBLANK;
      end
    endcase
  end
  always_comb begin
    tvalid_d = nstate == S_ACTIVE;
    tdata_d  = tvalid_d ? pix : '0;
    tlast_d  = tvalid_d && nx == X_LAST;
    tuser_d  = tvalid_d && nx == '0 && ny == '0;
  end
  assign busy = state != S_IDLE;
endmodule

// File: doc/axis_frame_source.md
Name: axis_frame_source

Overview:
- AXI-Stream video frame transmitter. Generates FRAME_WIDTH x FRAME_HEIGHT pixel frames with SOF on tuser and EOL on tlast.
- Drives the slave port of downstream pixel-processing blocks, for example the contrast LUT stage.
- Serves as the on-chip pattern source for bring-up and as the stimulus end of the pixel pipeline in benches.
- Honours tready backpressure and inserts programmable horizontal and vertical blanking.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- FRAME_WIDTH, 640, active pixels per line (>=2).
- FRAME_HEIGHT, 512, lines per frame (>=1).
- HBLANK, 0, idle cycles between lines (0 = back-to-back).
- VBLANK, 0, idle cycles between frames in continuous mode.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled; starts a frame when IDLE.
- continuous  in  1  when 1, the next frame follows automatically after VBLANK.
- pattern_sel  in  2  0 = H-ramp, 1 = V-ramp, 2 = 8x8 checker, 3 = constant.
- fill_value  in  DATA_WIDTH  pixel value for pattern 3.
- m_axis  AxiStreamIf.Master  -  tdata[DATA_WIDTH], tvalid, tready, tlast, tuser.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- frame_cnt  out  16  completed-frame counter; wraps at 65535 -> 0.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, x=0, y=0, tvalid=0, tdata=0, tlast=0, tuser=0, busy=0, frame_done=0, frame_cnt=0.
- Reset mid-frame abandons the frame with no tlast. After release, start must be reasserted.
- All m_axis outputs are registered.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE: start=1 at edge n latches pattern_sel and fill_value and moves to ACTIVE. tvalid=1 with pixel (0,0) and tuser=1 from cycle n+1.
- start while busy is ignored.
- pattern_sel and fill_value are frozen for the whole frame, including across continuous frames until the state returns to IDLE.
- ACTIVE handshake:
  - A beat transfers when tvalid && tready.
  - While tvalid && !tready: tdata, tlast and tuser stay stable and tvalid stays high.
  - On transfer with more pixels remaining in the line and no blanking needed, the next beat is presented the following cycle, giving 1 pixel/clk under continuous tready.
- Pixel (x,y) data:
  - H-ramp: x mod 2^DW.
  - V-ramp: y mod 2^DW.
  - Checker: all ones if x[3]^y[3], else 0.
  - Constant: fill_value.
- tuser=1 only on (0,0). tlast=1 only on x=FRAME_WIDTH-1.
- End of line, not last line: y increments and x=0. If HBLANK>0, go to HBLANK with tvalid=0 for exactly HBLANK cycles, then return to ACTIVE. If HBLANK=0, stay in ACTIVE.
- End of frame (x=W-1, y=H-1 transferred):
  - frame_done=1 the next cycle only; frame_cnt increments in that same cycle.
  - continuous=1 (sampled at the transfer edge): go to VBLANK, tvalid=0 for VBLANK cycles, then a new frame with tuser. With VBLANK=0 the next frame's (0,0) follows immediately.
  - continuous=0: go to IDLE.
- Dropping continuous mid-frame affects only the decision at end of frame.
- Counter widths are $clog2 of the dimension; blanking counter width is $clog2(max(HBLANK,VBLANK)+1).

Decomposition:
- Shared package axis_video_pkg:
  - pattern enum (PAT_HRAMP, PAT_VRAMP, PAT_CHECK, PAT_CONST);
  - FSM state typedef;
  - helper localparams for counter widths.
- The same package is later reused by the frame checker / sink.
- One sub-module is natural: axis_pattern_pixel. It is a purely combinational map (x, y, sel, fill) -> pixel, so patterns can be added without touching the FSM.

Test Plan:
- W=4, H=2, HBLANK=0, pattern 0, tready=1, start pulse:
  - 8 beats on consecutive cycles, tdata 0,1,2,3,0,1,2,3;
  - tuser on beat 0 only; tlast on beats 3 and 7;
  - frame_done one cycle after beat 7; frame_cnt=1; busy low afterwards.
- Backpressure: as above with tready low on alternate cycles, plus one 5-cycle stall on beat 2:
  - tdata, tlast and tuser held constant during stalls;
  - no beat lost or duplicated; accepted sequence identical.
- HBLANK=3, VBLANK=2, continuous=1, W=4, H=2:
  - exactly 3 tvalid=0 cycles between lines and 2 between frames;
  - second frame starts with tuser=1; frame_cnt reaches 2;
  - after dropping continuous, the source stops at IDLE.
- Pattern 2 at W=16, H=16, then pattern 3 with fill 0xA5:
  - checker: pixel (8,0)=0xFF, (8,8)=0x00;
  - constant: all beats 0xA5;
  - changing pattern_sel mid-frame has no effect.
- rst asserted mid-line (e.g. after beat 5):
  - outputs go to 0 without waiting for a clock;
  - after release no output until start;
  - the new frame begins at (0,0) with tuser=1 and frame_cnt=0.
- start held high while busy, and frame_cnt preset near wrap (run 65536 frames in fast sim or force the counter):
  - no restart mid-frame;
  - frame_cnt wraps 65535 -> 0 with frame_done still pulsing.
